// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the shared-ALU, single-memory datapath.
// Covers R-type, ADDI, LW, SW, BEQ/BNE/BLEZ/BGTZ and J, with memory stall/timeout and a trap state.
module multicycle_ctrl_fsm #(
  parameter bit MEM_WAIT  = 1'b1,
  parameter int TIMEOUT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Last stalled cycle before timeout: the count of stalls already seen equals 2^TIMEOUT_W-2.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_q;
  state_t               decode_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 illegal_q;
  logic                 bus_err_q;
  logic                 in_mem;
  logic                 mem_done;
  logic                 stall;
  logic                 timeout;
  logic                 branch_taken;

  // Memory handshake: the request (MemRead/MemWrite) is held every cycle of a memory
  // state; the access completes in the cycle mem_ready=1 (or at once when MEM_WAIT=0).
  assign in_mem   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_done = !MEM_WAIT || mem_ready;
  assign stall    = MEM_WAIT && in_mem && !mem_ready;
  assign timeout  = stall && (wait_cnt == WAIT_LAST);

  always_comb begin
    decode_next = S_TRAP;
    case (opCode)
      OP_RTYPE:                         decode_next = S_EXEC_R;
      OP_ADDI:                          decode_next = S_EXEC_I;
      OP_LW, OP_SW:                     decode_next = S_MEM_ADDR;
      6'b000100, 6'b000101,
      6'b000110, 6'b000111:             decode_next = S_BRANCH;
      OP_J:                             decode_next = S_JUMP;
      default:                          decode_next = S_TRAP;
    endcase
  end

  // opCode[1:0] selects BEQ, BNE, BLEZ, BGTZ in that order.
  always_comb begin
    branch_taken = 1'b0;
    case (opCode[1:0])
      2'b00:   branch_taken = zero;
      2'b01:   branch_taken = !zero;
      2'b10:   branch_taken = zero || neg;
      default: branch_taken = !zero && !neg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else if (timeout) begin
      state_q   <= S_TRAP;
      wait_cnt  <= '0;
      bus_err_q <= 1'b1;
    end else begin
      // A stall never changes state, so clearing on non-stall also clears on every transition.
      wait_cnt <= stall ? wait_cnt + 1'b1 : '0;
      case (state_q)
        S_FETCH:    if (mem_done) state_q <= S_DECODE;
        S_DECODE: begin
          state_q <= decode_next;
          if (decode_next == S_TRAP) illegal_q <= 1'b1;
        end
        S_EXEC_R,
        S_EXEC_I:   state_q <= S_ALU_WB;
        S_MEM_ADDR: state_q <= (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_done) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_done) state_q <= S_FETCH;
        S_ALU_WB,
        S_MEM_WB,
        S_BRANCH,
        S_JUMP:     state_q <= S_FETCH;
        default:    state_q <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    ALUOp    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_done;
          PCWrite = mem_done;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEM_ADDR, S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALU_WB: begin
          // Keep the execute-stage ALU setup so the result stays valid during write-back.
          RegWrite = 1'b1;
          ALUSrcA  = 1'b1;
          RegDst   = (opCode == OP_RTYPE);
          if (opCode == OP_RTYPE) ALUOp = 2'b10;
          else                    ALUSrcB = 2'b10;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWrite  = branch_taken;
        end
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = reset && illegal_q;
  assign bus_err = reset && bus_err_q;
  assign state   = reset ? state_q : S_FETCH;

endmodule
